// File: rtl/nibble_serializer_pkg.sv
// Shared types and helpers for the nibble serializer.
package nibble_serializer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Ceiling log2, with clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/nibble_serializer_if.sv
// Word input handshake and serial output bundle of the nibble serializer.
interface nibble_serializer_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             dout;
    logic             dout_valid;
    logic             dout_last;
    logic             busy;

    // Producer / observer side.
    modport master (
        output din, din_valid,
        input  din_ready, dout, dout_valid, dout_last, busy
    );

    // Serializer side.
    modport slave (
        input  din, din_valid,
        output din_ready, dout, dout_valid, dout_last, busy
    );
endinterface

// File: rtl/nibble_serializer_bit_tick_gen.sv
// Bit period divider: a CLK_DIV down-counter restarted at every bit start.
// tick_o is high in the first cycle of each period, end_o in the last one.
module bit_tick_gen
    import nibble_serializer_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    input  logic en_i,
    output logic tick_o,
    output logic end_o
);
    localparam int unsigned DivW = clog2(CLK_DIV + 1);

    logic [DivW-1:0] cnt_q, cnt_d;
    logic            tick_q, tick_d;

    // Reload on restart, otherwise count down to zero and stick there.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (restart_i) begin
            cnt_d  = DivW'(CLK_DIV - 1);
            tick_d = 1'b1;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - DivW'(1);
        end
    end

    // Counter and tick registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;
    assign end_o  = (cnt_q == '0);

endmodule

// File: rtl/nibble_serializer.sv
// Parallel-in serial-out transmitter feeding a downstream serial-in shifter.
module nibble_serializer
    import nibble_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned CLK_DIV   = 1,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    nibble_serializer_if.slave   bus
);
    localparam int unsigned CntW = clog2(WIDTH);

    if (CLK_DIV == 0) begin : g_bad_clk_div
        $error("nibble_serializer: CLK_DIV must be at least 1");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic             dout_q, dout_d;
    logic             tick;
    logic             period_end;
    logic             last_bit;
    logic             ready;
    logic             accept;
    logic             advance;

    assign last_bit = (bit_cnt_q == CntW'(WIDTH - 1));
    // Ready in idle, or in the final cycle of the last bit for gapless words.
    assign ready    = !rst && ((state_q == ST_IDLE) || (period_end && last_bit));
    assign accept   = bus.din_valid && ready;
    assign advance  = (state_q == ST_SHIFT) && period_end && !last_bit;

    bit_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .restart_i (accept || advance),
        .en_i      (state_q == ST_SHIFT),
        .tick_o    (tick),
        .end_o     (period_end)
    );

    // Next state, shift buffer, bit counter and serial bit.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        dout_d    = dout_q;
        if (accept) begin
            state_d   = ST_SHIFT;
            shreg_d   = bus.din;
            bit_cnt_d = '0;
            dout_d    = MSB_FIRST ? bus.din[WIDTH-1] : bus.din[0];
        end else if (advance) begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
            if (MSB_FIRST) begin
                shreg_d = shreg_q << 1;
                dout_d  = shreg_q[WIDTH-2];
            end else begin
                shreg_d = shreg_q >> 1;
                dout_d  = shreg_q[1];
            end
        end else if ((state_q == ST_SHIFT) && period_end && last_bit) begin
            state_d = ST_IDLE;
            dout_d  = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            dout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            dout_q    <= dout_d;
        end
    end

    assign bus.din_ready  = ready;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = tick;
    assign bus.dout_last  = tick && last_bit;
    assign bus.busy       = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed self-checking bench for nibble_serializer.
module tb_nibble_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] sh;

    always #5 clk = ~clk;

    nibble_serializer_if #(.WIDTH(4)) bus1 ();
    nibble_serializer_if #(.WIDTH(4)) bus3 ();
    nibble_serializer_if #(.WIDTH(4)) busm ();

    nibble_serializer #(.WIDTH(4), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );
    nibble_serializer #(.WIDTH(4), .CLK_DIV(3), .MSB_FIRST(1'b0)) dut3 (
        .clk (clk), .rst (rst), .bus (bus3)
    );
    nibble_serializer #(.WIDTH(4), .CLK_DIV(1), .MSB_FIRST(1'b1)) dutm (
        .clk (clk), .rst (rst), .bus (busm)
    );

    // Downstream 4-bit shifter filling from its MSB end.
    always @(posedge clk) begin
        if (rst) sh <= 4'h0;
        else if (bus1.dout_valid) sh <= {bus1.dout, sh[3:1]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (bus1.din_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b want 0", bus1.din_ready);
        end
        tick();
        checks++;
        if ({bus1.dout, bus1.dout_valid, bus1.dout_last, bus1.busy} !== 4'b0000) begin
            errors++; $display("FAIL reset_outs1 got %b want 0000",
                {bus1.dout, bus1.dout_valid, bus1.dout_last, bus1.busy});
        end
        checks++;
        if ({bus3.dout, bus3.dout_valid, busm.dout, busm.busy, bus3.din_ready} !== 5'b0) begin
            errors++; $display("FAIL reset_outs_other got %b want 00000",
                {bus3.dout, bus3.dout_valid, busm.dout, busm.busy, bus3.din_ready});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus1.din_ready !== 1'b1) begin
            errors++; $display("FAIL idle_ready got %b want 1", bus1.din_ready);
        end
    endtask

    task automatic test_basic();
        logic [3:0] bits;
        bits = 4'b1011;
        bus1.din = 4'b1011;
        bus1.din_valid = 1'b1;
        tick();
        bus1.din_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus1.dout, bus1.dout_valid, bus1.dout_last, bus1.busy} !==
                {bits[i], 1'b1, (i == 3), 1'b1}) begin
                errors++; $display("FAIL basic_bit%0d got %b want %b", i,
                    {bus1.dout, bus1.dout_valid, bus1.dout_last, bus1.busy},
                    {bits[i], 1'b1, (i == 3), 1'b1});
            end
            tick();
        end
        checks++;
        if ({bus1.dout, bus1.dout_valid, bus1.busy} !== 3'b000) begin
            errors++; $display("FAIL basic_end got %b want 000",
                {bus1.dout, bus1.dout_valid, bus1.busy});
        end
        checks++;
        if (sh !== 4'b1011) begin
            errors++; $display("FAIL basic_shifter got %h want b", sh);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits;
        bits = 8'b0101_1010;  // index i = bit sent in cycle i+1: 0,1,0,1,1,0,1,0
        bus1.din = 4'hA;
        bus1.din_valid = 1'b1;
        tick();
        bus1.din = 4'h5;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({bus1.dout, bus1.dout_valid, bus1.dout_last} !==
                {bits[i], 1'b1, (i == 3 || i == 7)}) begin
                errors++; $display("FAIL b2b_bit%0d got %b want %b", i,
                    {bus1.dout, bus1.dout_valid, bus1.dout_last},
                    {bits[i], 1'b1, (i == 3 || i == 7)});
            end
            if (i < 4) begin
                checks++;
                if (bus1.din_ready !== (i == 3)) begin
                    errors++; $display("FAIL b2b_ready%0d got %b want %b", i,
                        bus1.din_ready, (i == 3));
                end
            end
            if (i == 4) bus1.din_valid = 1'b0;
            tick();
        end
        checks++;
        if ({bus1.dout_valid, bus1.busy} !== 2'b00) begin
            errors++; $display("FAIL b2b_end got %b want 00", {bus1.dout_valid, bus1.busy});
        end
    endtask

    task automatic test_divided();
        logic ev, ed, eb, el;
        bus3.din = 4'b0110;
        bus3.din_valid = 1'b1;
        tick();
        bus3.din_valid = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            ev = (c == 1 || c == 4 || c == 7 || c == 10);
            ed = (c >= 4 && c <= 9);
            eb = (c <= 12);
            el = (c == 10);
            checks++;
            if ({bus3.dout, bus3.dout_valid, bus3.dout_last, bus3.busy} !== {ed, ev, el, eb}) begin
                errors++; $display("FAIL div_cycle%0d got %b want %b", c,
                    {bus3.dout, bus3.dout_valid, bus3.dout_last, bus3.busy}, {ed, ev, el, eb});
            end
            tick();
        end
    endtask

    task automatic test_valid_busy();
        logic [3:0] bits1, bits2;
        logic [3:0] noise;
        bits1 = 4'hC;
        bits2 = 4'h9;
        noise = 4'h3;
        bus1.din = 4'hC;
        bus1.din_valid = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus1.din = (i == 3) ? 4'h9 : noise;
            noise = noise + 4'h5;
            checks++;
            if ({bus1.dout, bus1.dout_valid, bus1.din_ready} !== {bits1[i], 1'b1, (i == 3)}) begin
                errors++; $display("FAIL vb_bit%0d got %b want %b", i,
                    {bus1.dout, bus1.dout_valid, bus1.din_ready}, {bits1[i], 1'b1, (i == 3)});
            end
            tick();
        end
        bus1.din_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus1.dout, bus1.dout_valid, bus1.dout_last} !== {bits2[i], 1'b1, (i == 3)}) begin
                errors++; $display("FAIL vb_next%0d got %b want %b", i,
                    {bus1.dout, bus1.dout_valid, bus1.dout_last}, {bits2[i], 1'b1, (i == 3)});
            end
            tick();
        end
        checks++;
        if (bus1.busy !== 1'b0) begin
            errors++; $display("FAIL vb_end got %b want 0", bus1.busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] bits;
        bits = 4'b0011;
        bus1.din = 4'hF;
        bus1.din_valid = 1'b1;
        tick();
        bus1.din_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (bus1.din_ready !== 1'b0) begin
            errors++; $display("FAIL mid_ready got %b want 0", bus1.din_ready);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({bus1.dout, bus1.dout_valid, bus1.dout_last, bus1.busy} !== 4'b0000) begin
                errors++; $display("FAIL mid_quiet%0d got %b want 0000", c,
                    {bus1.dout, bus1.dout_valid, bus1.dout_last, bus1.busy});
            end
            tick();
        end
        bus1.din = 4'h3;
        bus1.din_valid = 1'b1;
        tick();
        bus1.din_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus1.dout, bus1.dout_valid, bus1.dout_last} !== {bits[i], 1'b1, (i == 3)}) begin
                errors++; $display("FAIL mid_after%0d got %b want %b", i,
                    {bus1.dout, bus1.dout_valid, bus1.dout_last}, {bits[i], 1'b1, (i == 3)});
            end
            tick();
        end
        checks++;
        if (sh !== 4'h3) begin
            errors++; $display("FAIL mid_shifter got %h want 3", sh);
        end
    endtask

    task automatic test_msb_first();
        logic [3:0] seq;
        seq = 4'b0001;  // index i = bit sent in cycle i+1: 1,0,0,0
        busm.din = 4'b1000;
        busm.din_valid = 1'b1;
        tick();
        busm.din_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({busm.dout, busm.dout_valid, busm.dout_last} !== {seq[i], 1'b1, (i == 3)}) begin
                errors++; $display("FAIL msb_bit%0d got %b want %b", i,
                    {busm.dout, busm.dout_valid, busm.dout_last}, {seq[i], 1'b1, (i == 3)});
            end
            tick();
        end
        checks++;
        if ({busm.dout_valid, busm.busy} !== 2'b00) begin
            errors++; $display("FAIL msb_end got %b want 00", {busm.dout_valid, busm.busy});
        end
    endtask

    initial begin
        bus1.din = '0; bus1.din_valid = 1'b0;
        bus3.din = '0; bus3.din_valid = 1'b0;
        busm.din = '0; busm.din_valid = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_back_to_back();
        test_divided();
        test_valid_busy();
        test_reset_mid();
        test_msb_first();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
